// File: rtl/ex_pkg.sv
// Shared types for the EX stage: ALU opcode encoding, multiplier FSM states
// and the architectural flags record.
package ex_pkg;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_MUL  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_RSVD = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } ex_state_e;

    typedef struct packed {
        logic negative;
        logic zero;
        logic overflow;
        logic carry;
    } flags_t;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational single-cycle ALU with NZVC flag generation. MUL and the
// reserved opcode yield zero and request no flag write.
module alu_w
    import ex_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  alu_op_e          i_op,
    output logic [WIDTH-1:0] o_result,
    output flags_t           o_flags,
    output logic             o_flags_we
);

    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;

    // Subtraction reuses the adder as A + ~B + 1.
    assign w_sub   = (i_op == OP_SUB);
    assign w_b_eff = w_sub ? ~i_b : i_b;
    assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        o_result         = '0;
        o_flags_we       = 1'b0;
        o_flags.overflow = 1'b0;
        o_flags.carry    = 1'b0;
        unique case (i_op)
            OP_PASS: begin
                o_result   = i_b;
                o_flags_we = 1'b1;
            end
            OP_ADD, OP_SUB: begin
                o_result         = w_sum[WIDTH-1:0];
                o_flags_we       = 1'b1;
                o_flags.carry    = w_sum[WIDTH];
                o_flags.overflow = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                                   (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND: begin
                o_result   = i_a & i_b;
                o_flags_we = 1'b1;
            end
            OP_OR: begin
                o_result   = i_a | i_b;
                o_flags_we = 1'b1;
            end
            OP_XOR: begin
                o_result   = i_a ^ i_b;
                o_flags_we = 1'b1;
            end
            default: begin
                o_result   = '0;
                o_flags_we = 1'b0;
            end
        endcase
        o_flags.negative = o_result[WIDTH-1];
        o_flags.zero     = ~|o_result;
    end

endmodule

// File: rtl/ex_stage.sv
// EX pipeline stage: ALU, branch-target adder and flags register. Defining
// EX_MUL_EN adds a one-bit-per-cycle shift-add multiplier on ALUop 001.
module ex_stage
    import ex_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] ReadData1,
    input  logic [WIDTH-1:0] ReadData2,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] ALU_imm_extend,
    input  logic [WIDTH-1:0] BR_to_shift,
    input  logic [2:0]       ALUop,
    input  logic             ALUsrc,
    input  logic             update,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALU_result,
    output logic [WIDTH-1:0] ReadData2_out,
    output logic [WIDTH-1:0] new_PC2,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic             busy
);

    alu_op_e          w_op;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_alu_result;
    flags_t           w_alu_flags;
    logic             w_alu_flags_we;
    logic             w_capture;
    logic             w_is_mul;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_result;
    logic             w_mul_update;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_rd2;
    logic [WIDTH-1:0] r_pc2;
    flags_t           r_flags;

    assign w_op      = alu_op_e'(ALUop);
    assign w_b       = ALUsrc ? ALU_imm_extend : ReadData2;
    assign w_target  = PC + (BR_to_shift << BR_SHIFT);
    assign w_capture = in_valid && !stall && !flush && !busy;

    alu_w #(.WIDTH(WIDTH)) u_alu (
        .i_a        (ReadData1),
        .i_b        (w_b),
        .i_op       (w_op),
        .o_result   (w_alu_result),
        .o_flags    (w_alu_flags),
        .o_flags_we (w_alu_flags_we)
    );

`ifdef EX_MUL_EN
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ex_state_e        r_state;
    ex_state_e        w_state_nxt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mul_update;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Stall freezes the FSM; flush aborts any multiply back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (!stall) begin
            if (flush) begin
                w_state_nxt = S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE:  if (w_capture && w_is_mul) w_state_nxt = S_MUL;
                    S_MUL:   if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
                    S_DONE:  w_state_nxt = S_IDLE;
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_mul_update <= 1'b0;
        end else if (!stall) begin
            if (w_capture && w_is_mul) begin
                r_mcand      <= ReadData1;
                r_mplier     <= w_b;
                r_acc        <= '0;
                r_cnt        <= '0;
                r_mul_update <= update;
            end else if (r_state == S_MUL) begin
                if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign w_is_mul     = (w_op == OP_MUL);
    assign w_mul_done   = (r_state == S_DONE);
    assign w_mul_result = r_acc;
    assign w_mul_update = r_mul_update;
`else
    assign busy         = 1'b0;
    assign w_is_mul     = 1'b0;
    assign w_mul_done   = 1'b0;
    assign w_mul_result = '0;
    assign w_mul_update = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_rd2       <= '0;
            r_pc2       <= '0;
            r_flags     <= '0;
        end else if (!stall) begin
            // NOTE: non-blocking assignments let the later branches override the default cleanly.
            r_out_valid <= 1'b0;
            if (w_capture) begin
                r_rd2 <= ReadData2;
                r_pc2 <= w_target;
                if (!w_is_mul) begin
                    r_out_valid <= 1'b1;
                    r_result    <= w_alu_result;
                    if (update && w_alu_flags_we) r_flags <= w_alu_flags;
                end
            end else if (w_mul_done && !flush) begin
                r_out_valid <= 1'b1;
                r_result    <= w_mul_result;
                if (w_mul_update) begin
                    r_flags <= flags_t'{negative: w_mul_result[WIDTH-1],
                                        zero:     ~|w_mul_result,
                                        overflow: 1'b0,
                                        carry:    1'b0};
                end
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign ALU_result    = r_result;
    assign ReadData2_out = r_rd2;
    assign new_PC2       = r_pc2;
    assign negative      = r_flags.negative;
    assign zero          = r_flags.zero;
    assign overflow      = r_flags.overflow;
    assign carry_out     = r_flags.carry;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: a table of directed ALU vectors followed by
// stall, flush and reset sequences; multiplier sequences when EX_MUL_EN is set.
module tb_ex_stage;

    typedef struct {
        logic [2:0]  op;
        logic        src;
        logic        upd;
        logic [63:0] a;
        logic [63:0] rd2;
        logic [63:0] imm;
        logic [63:0] pc;
        logic [63:0] br;
        logic [63:0] exp_res;
        logic [3:0]  exp_flags;
        logic [63:0] exp_pc2;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] br;
    logic [2:0]  op;
    logic        src;
    logic        upd;

    logic        out_valid;
    logic [63:0] alu_result;
    logic [63:0] rd2_out;
    logic [63:0] new_pc2;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    ex_stage #(.WIDTH(64), .BR_SHIFT(2)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .stall          (stall),
        .flush          (flush),
        .ReadData1      (rd1),
        .ReadData2      (rd2),
        .PC             (pc),
        .ALU_imm_extend (imm),
        .BR_to_shift    (br),
        .ALUop          (op),
        .ALUsrc         (src),
        .update         (upd),
        .out_valid      (out_valid),
        .ALU_result     (alu_result),
        .ReadData2_out  (rd2_out),
        .new_PC2        (new_pc2),
        .negative       (negative),
        .zero           (zero),
        .overflow       (overflow),
        .carry_out      (carry_out),
        .busy           (busy)
    );

`ifdef EX_MUL_EN
    logic       m8_out_valid;
    logic [7:0] m8_result;
    logic [7:0] m8_rd2_out;
    logic [7:0] m8_pc2;
    logic       m8_n;
    logic       m8_z;
    logic       m8_v;
    logic       m8_c;
    logic       m8_busy;

    ex_stage #(.WIDTH(8), .BR_SHIFT(2)) u_dut8 (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .stall          (stall),
        .flush          (flush),
        .ReadData1      (rd1[7:0]),
        .ReadData2      (rd2[7:0]),
        .PC             (pc[7:0]),
        .ALU_imm_extend (imm[7:0]),
        .BR_to_shift    (br[7:0]),
        .ALUop          (op),
        .ALUsrc         (src),
        .update         (upd),
        .out_valid      (m8_out_valid),
        .ALU_result     (m8_result),
        .ReadData2_out  (m8_rd2_out),
        .new_PC2        (m8_pc2),
        .negative       (m8_n),
        .zero           (m8_z),
        .overflow       (m8_v),
        .carry_out      (m8_c),
        .busy           (m8_busy)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [2:0] v_op, input logic v_src, input logic v_upd,
                                input logic [63:0] v_a, input logic [63:0] v_rd2,
                                input logic [63:0] v_imm, input logic [63:0] v_pc,
                                input logic [63:0] v_br, input logic [63:0] v_res,
                                input logic [3:0] v_fl, input logic [63:0] v_pc2);
        vec_t v;
        v.op = v_op;  v.src = v_src; v.upd = v_upd;
        v.a = v_a;    v.rd2 = v_rd2; v.imm = v_imm;
        v.pc = v_pc;  v.br = v_br;
        v.exp_res = v_res; v.exp_flags = v_fl; v.exp_pc2 = v_pc2;
        return v;
    endfunction

    task automatic drive(input logic [2:0] t_op, input logic [63:0] t_a, input logic [63:0] t_b,
                         input logic t_upd);
        op = t_op; rd1 = t_a; rd2 = t_b; upd = t_upd;
        src = 1'b0; imm = '0; pc = '0; br = '0;
    endtask

    vec_t vecs[$];
    int   busy_cycles;
    logic ov_during;

    initial begin
        reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(3'b000, 64'h0, 64'h0, 1'b0);

        // Flags column is {negative, zero, overflow, carry_out}; each row follows the previous one.
        vecs.push_back(mk(3'b010, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 64'h100, '1,
                          64'h8000_0000_0000_0000, 4'b1010, 64'hFC));
        vecs.push_back(mk(3'b011, 0, 1, 64'h5, 64'h5, 64'h0, 64'h1000, 64'h4, 64'h0, 4'b0101, 64'h1010));
        vecs.push_back(mk(3'b100, 0, 0, 64'hF0, 64'h3C, 64'h0, 64'h0, 64'h0, 64'h30, 4'b0101, 64'h0));
        vecs.push_back(mk(3'b101, 1, 1, 64'hF0, 64'hDEAD, 64'h0F, 64'h2000, 64'h1, 64'hFF, 4'b0000, 64'h2004));
        vecs.push_back(mk(3'b110, 1, 1, '1, 64'h55, 64'h0F, 64'h0, 64'h0,
                          64'hFFFF_FFFF_FFFF_FFF0, 4'b1000, 64'h0));
        vecs.push_back(mk(3'b000, 0, 1, 64'h1234, 64'h0, 64'h99, 64'h0, 64'h0, 64'h0, 4'b0100, 64'h0));
        vecs.push_back(mk(3'b011, 0, 1, 64'h0, 64'h1, 64'h0, 64'h0, 64'h0, '1, 4'b1000, 64'h0));
        vecs.push_back(mk(3'b011, 0, 1, 64'h8000_0000_0000_0000, 64'h1, 64'h0, 64'h0, 64'h0,
                          64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 64'h0));
        vecs.push_back(mk(3'b111, 0, 1, 64'h3, 64'h4, 64'h0, 64'h40, 64'h2, 64'h0, 4'b0011, 64'h48));
`ifndef EX_MUL_EN
        vecs.push_back(mk(3'b001, 0, 1, 64'h3, 64'h4, 64'h0, 64'h0, 64'h0, 64'h0, 4'b0011, 64'h0));
`endif
        vecs.push_back(mk(3'b010, 0, 1, '1, 64'h1, 64'h0, 64'h0, 64'h0, 64'h0, 4'b0101, 64'h0));
        vecs.push_back(mk(3'b010, 0, 0, 64'h2, 64'h3, 64'h0, 64'h0, 64'h0, 64'h5, 4'b0101, 64'h0));
        vecs.push_back(mk(3'b000, 1, 1, 64'h0, 64'h7, 64'h8000_0000_0000_0000, 64'h0, 64'h0,
                          64'h8000_0000_0000_0000, 4'b1000, 64'h0));

        // Reset state, then idle cycles after release must keep everything cleared.
        tick(); tick();
        check("rst_valid", out_valid, 0);
        check("rst_result", alu_result, 0);
        check("rst_flags", {negative, zero, overflow, carry_out}, 0);
        check("rst_pc2", new_pc2, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        tick();
        check("idle_valid", out_valid, 0);
        check("idle_rd2", rd2_out, 0);

        in_valid = 1'b1;
        foreach (vecs[i]) begin
            op = vecs[i].op; src = vecs[i].src; upd = vecs[i].upd;
            rd1 = vecs[i].a; rd2 = vecs[i].rd2; imm = vecs[i].imm;
            pc = vecs[i].pc; br = vecs[i].br;
            tick();
            check($sformatf("v%0d_valid", i), out_valid, 1);
            check($sformatf("v%0d_result", i), alu_result, vecs[i].exp_res);
            check($sformatf("v%0d_flags", i), {negative, zero, overflow, carry_out}, vecs[i].exp_flags);
            check($sformatf("v%0d_pc2", i), new_pc2, vecs[i].exp_pc2);
            check($sformatf("v%0d_rd2", i), rd2_out, vecs[i].rd2);
            check($sformatf("v%0d_busy", i), busy, 0);
        end

        // Stall freezes outputs and flags while new operands are offered.
        drive(3'b010, 64'h1, 64'h1, 1'b1);
        pc = 64'h100; br = '1;
        tick();
        check("pre_stall_result", alu_result, 64'h2);
        check("pre_stall_flags", {negative, zero, overflow, carry_out}, 4'b0000);
        stall = 1'b1;
        drive(3'b011, 64'h9, 64'h77, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall%0d_valid", c), out_valid, 1);
            check($sformatf("stall%0d_result", c), alu_result, 64'h2);
            check($sformatf("stall%0d_pc2", c), new_pc2, 64'hFC);
            check($sformatf("stall%0d_rd2", c), rd2_out, 64'h1);
            check($sformatf("stall%0d_flags", c), {negative, zero, overflow, carry_out}, 4'b0000);
        end

        // Flush coinciding with a capture: nothing captured, flags untouched.
        stall = 1'b0; flush = 1'b1;
        drive(3'b011, 64'h5, 64'h5, 1'b1);
        tick();
        check("flush_valid", out_valid, 0);
        check("flush_flags", {negative, zero, overflow, carry_out}, 4'b0000);
        check("flush_result", alu_result, 64'h2);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("bubble_valid", out_valid, 0);

        // Asynchronous reset clears outputs without waiting for an edge.
        in_valid = 1'b1;
        drive(3'b010, 64'h3, 64'h4, 1'b1);
        tick();
        check("pre_rst_result", alu_result, 64'h7);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_result", alu_result, 0);
        check("arst_rd2", rd2_out, 0);
        tick();
        reset = 1'b0;
        tick(); tick();
        check("post_rst_valid", out_valid, 0);
        check("post_rst_result", alu_result, 0);

`ifdef EX_MUL_EN
        // 8-bit multiply 13 x 11: busy across MUL and DONE, then a single valid pulse.
        in_valid = 1'b1;
        drive(3'b001, 64'd13, 64'd11, 1'b1);
        tick();
        in_valid = 1'b0;
        busy_cycles = 0;
        ov_during = 1'b0;
        for (int c = 0; c < 40 && m8_busy; c++) begin
            busy_cycles++;
            if (m8_out_valid) ov_during = 1'b1;
            tick();
        end
        check("mul_busy_cycles", busy_cycles, 9);
        check("mul_valid_while_busy", ov_during, 0);
        check("mul_valid", m8_out_valid, 1);
        check("mul_result", m8_result, 8'h8F);
        check("mul_flags", {m8_n, m8_z, m8_v, m8_c}, 4'b1000);
        tick();
        check("mul_valid_pulse", m8_out_valid, 0);

        // Reset four cycles into a multiply, then an ordinary add.
        in_valid = 1'b1;
        drive(3'b001, 64'd13, 64'd11, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("mul_mid_busy", m8_busy, 1);
        reset = 1'b1;
        #1;
        check("mul_rst_busy", m8_busy, 0);
        check("mul_rst_valid", m8_out_valid, 0);
        tick();
        reset = 1'b0;
        in_valid = 1'b1;
        drive(3'b010, 64'h7F, 64'h1, 1'b1);
        tick();
        in_valid = 1'b0;
        check("mul_after_valid", m8_out_valid, 1);
        check("mul_after_result", m8_result, 8'h80);
        check("mul_after_flags", {m8_n, m8_z, m8_v, m8_c}, 4'b1010);
        check("mul_after_busy", m8_busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
